// File: rtl/seed_stream_accumulator_if.sv
// Handshake and status bundle for seed_stream_accumulator.
// The master side is the controller/TRNG/consumer environment, the slave side is the accumulator.
interface seed_stream_accumulator_if #(
  parameter int SEED_WIDTH = 256,
  parameter int IN_WIDTH   = 8,
  parameter int CNT_WIDTH  = $clog2(SEED_WIDTH / IN_WIDTH) + 1
);
  logic                  start;
  logic                  abort;
  logic                  trng_valid;
  logic [IN_WIDTH-1:0]   trng_data;
  logic                  trng_ready;
  logic [SEED_WIDTH-1:0] seed;
  logic                  seed_valid;
  logic                  seed_ready;
  logic                  collecting;
  logic                  health_fail;
  logic [CNT_WIDTH-1:0]  word_count;

  modport master (
    output start, abort, trng_valid, trng_data, seed_ready,
    input  trng_ready, seed, seed_valid, collecting, health_fail, word_count
  );

  modport slave (
    input  start, abort, trng_valid, trng_data, seed_ready,
    output trng_ready, seed, seed_valid, collecting, health_fail, word_count
  );
endinterface

// File: rtl/seed_stream_accumulator.sv
// Assembles TRNG words into SEED_WIDTH-bit seeds, runs a repetition-count
// health test on the word stream and offers finished seeds on a valid/ready slot.
module seed_stream_accumulator #(
  parameter int SEED_WIDTH = 256,
  parameter int IN_WIDTH   = 8,
  parameter int RCT_CUTOFF = 4,
  parameter int CONTINUOUS = 0
) (
  input logic                     clk,
  input logic                     rst,
  seed_stream_accumulator_if.slave bus
);
  localparam int WORDS = SEED_WIDTH / IN_WIDTH;
  localparam int CNT_W = $clog2(WORDS) + 1;
  localparam int REP_W = (RCT_CUTOFF > 1) ? $clog2(RCT_CUTOFF + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  if ((SEED_WIDTH % IN_WIDTH) != 0 || SEED_WIDTH <= IN_WIDTH) begin : g_bad_params
    $error("SEED_WIDTH must be a multiple of IN_WIDTH and greater than IN_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, FULL, FAIL} state_t;

  // Where the FSM goes once a seed has been handed to the output slot.
  localparam state_t DONE_STATE = (CONTINUOUS != 0) ? COLLECT : IDLE;

  state_t                state, state_next;
  logic [SEED_WIDTH-1:0] shift_buf, shift_next, load_value, seed_q;
  logic [CNT_W-1:0]      word_count_q;
  logic [REP_W-1:0]      rep, rep_next;
  logic [IN_WIDTH-1:0]   last_word;
  logic                  seed_valid_q, health_fail_q;
  logic                  accept, slot_free, rct_trip, seed_done, load_seed;

  assign accept     = (state == COLLECT) && bus.trng_valid;
  assign slot_free  = !seed_valid_q || bus.seed_ready;
  assign shift_next = {shift_buf[SEED_WIDTH-IN_WIDTH-1:0], bus.trng_data};

  // The first word of every seed restarts the run length.
  assign rep_next = (word_count_q == '0)         ? REP_W'(1) :
                    (bus.trng_data == last_word) ? rep + REP_W'(1) : REP_W'(1);

  // A trip discards the offending word, so it overrides seed completion.
  assign rct_trip  = (RCT_CUTOFF > 0) && accept && (rep_next == REP_W'(RCT_CUTOFF));
  assign seed_done = accept && (word_count_q == LAST_IDX) && !rct_trip;

  assign load_seed  = !bus.abort && slot_free &&
                      (((state == COLLECT) && seed_done) || (state == FULL));
  assign load_value = (state == FULL) ? shift_buf : shift_next;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; abort beats start and word acceptance everywhere.
  always_comb begin
    // NOTE: default first so no path through the block leaves state_next unassigned (no latch).
    state_next = state;
    if (bus.abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_next = COLLECT;
        COLLECT: begin
          if (rct_trip)       state_next = FAIL;
          else if (seed_done) state_next = slot_free ? DONE_STATE : FULL;
        end
        FULL:    if (slot_free) state_next = DONE_STATE;
        FAIL:    if (bus.start) state_next = COLLECT;
        default: state_next = IDLE;
      endcase
    end
  end

  // Status outputs decoded straight from the state flops.
  always_comb begin
    bus.collecting = (state == COLLECT);
    bus.trng_ready = (state == COLLECT);
  end

  // Collection buffer, word counter, repetition test and health flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the buffer holds secret material, so it is explicitly reset rather than left undefined.
      shift_buf     <= '0;
      word_count_q  <= '0;
      rep           <= '0;
      last_word     <= '0;
      health_fail_q <= 1'b0;
    end else if (bus.abort) begin
      shift_buf     <= '0;
      word_count_q  <= '0;
      rep           <= '0;
      health_fail_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift_buf    <= '0;
            word_count_q <= '0;
            rep          <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            if (rct_trip) begin
              shift_buf     <= '0;
              word_count_q  <= '0;
              rep           <= '0;
              health_fail_q <= 1'b1;
            end else if (seed_done && slot_free) begin
              shift_buf    <= '0;
              word_count_q <= '0;
              rep          <= rep_next;
              last_word    <= bus.trng_data;
            end else begin
              // Also covers the completed-but-slot-busy case: the seed parks in the buffer.
              shift_buf    <= shift_next;
              word_count_q <= word_count_q + CNT_W'(1);
              rep          <= rep_next;
              last_word    <= bus.trng_data;
            end
          end
        end
        FULL: begin
          if (slot_free) begin
            shift_buf    <= '0;
            word_count_q <= '0;
          end
        end
        FAIL: begin
          if (bus.start) begin
            shift_buf     <= '0;
            word_count_q  <= '0;
            rep           <= '0;
            health_fail_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output slot: load a finished seed, or zeroize it once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_q       <= '0;
      seed_valid_q <= 1'b0;
    end else if (load_seed) begin
      seed_q       <= load_value;
      seed_valid_q <= 1'b1;
    end else if (seed_valid_q && bus.seed_ready) begin
      seed_q       <= '0;
      seed_valid_q <= 1'b0;
    end
  end

  assign bus.seed        = seed_q;
  assign bus.seed_valid  = seed_valid_q;
  assign bus.health_fail = health_fail_q;
  assign bus.word_count  = word_count_q;
endmodule

// File: tb/tb_seed_stream_accumulator.sv
// Directed testbench for seed_stream_accumulator: default, continuous and
// 32-bit-word instances share one clock and reset.
module tb_seed_stream_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  localparam logic [255:0] SEED_01_20 =
    256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;
  localparam logic [255:0] SEED_21_40 =
    256'h2122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f40;
  localparam logic [255:0] SEED_40_5F =
    256'h404142434445464748494a4b4c4d4e4f505152535455565758595a5b5c5d5e5f;
  localparam logic [127:0] SEED_W32 = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;

  seed_stream_accumulator_if #(.SEED_WIDTH(256), .IN_WIDTH(8))  bus_def ();
  seed_stream_accumulator_if #(.SEED_WIDTH(256), .IN_WIDTH(8))  bus_cont ();
  seed_stream_accumulator_if #(.SEED_WIDTH(128), .IN_WIDTH(32)) bus_w32 ();

  seed_stream_accumulator u_def (.clk(clk), .rst(rst), .bus(bus_def));
  seed_stream_accumulator #(.CONTINUOUS(1)) u_cont (.clk(clk), .rst(rst), .bus(bus_cont));
  seed_stream_accumulator #(.SEED_WIDTH(128), .IN_WIDTH(32)) u_w32 (.clk(clk), .rst(rst), .bus(bus_w32));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_def(input logic [7:0] b);
    bus_def.trng_valid = 1'b1;
    bus_def.trng_data  = b;
    tick();
  endtask

  task automatic feed_cont(input logic [7:0] b);
    bus_cont.trng_valid = 1'b1;
    bus_cont.trng_data  = b;
    tick();
  endtask

  task automatic test_reset();
    tick();
    checks++; if (bus_def.seed_valid !== 1'b0) begin errors++; $display("FAIL rst_seed_valid: got %b expected 0", bus_def.seed_valid); end
    checks++; if (bus_def.seed !== 256'h0) begin errors++; $display("FAIL rst_seed: got %h expected 0", bus_def.seed); end
    checks++; if (bus_def.trng_ready !== 1'b0) begin errors++; $display("FAIL rst_trng_ready: got %b expected 0", bus_def.trng_ready); end
    checks++; if (bus_def.health_fail !== 1'b0) begin errors++; $display("FAIL rst_health_fail: got %b expected 0", bus_def.health_fail); end
    checks++; if (bus_def.word_count !== 6'd0) begin errors++; $display("FAIL rst_word_count: got %0d expected 0", bus_def.word_count); end
    checks++; if (bus_def.collecting !== 1'b0) begin errors++; $display("FAIL rst_collecting: got %b expected 0", bus_def.collecting); end
    rst = 1'b0;
    tick();
    checks++; if (bus_cont.trng_ready !== 1'b0) begin errors++; $display("FAIL idle_cont_trng_ready: got %b expected 0", bus_cont.trng_ready); end
  endtask

  task automatic test_single_seed();
    bus_def.start = 1'b1;
    tick();
    bus_def.start = 1'b0;
    checks++; if (bus_def.collecting !== 1'b1) begin errors++; $display("FAIL t1_collecting: got %b expected 1", bus_def.collecting); end
    checks++; if (bus_def.trng_ready !== 1'b1) begin errors++; $display("FAIL t1_trng_ready: got %b expected 1", bus_def.trng_ready); end
    for (int i = 1; i <= 32; i++) begin
      feed_def(8'(i));
      if (i == 31) begin
        checks++; if (bus_def.word_count !== 6'd31) begin errors++; $display("FAIL t1_count31: got %0d expected 31", bus_def.word_count); end
        checks++; if (bus_def.seed_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid: got %b expected 0", bus_def.seed_valid); end
      end
    end
    bus_def.trng_valid = 1'b0;
    checks++; if (bus_def.seed_valid !== 1'b1) begin errors++; $display("FAIL t1_seed_valid: got %b expected 1", bus_def.seed_valid); end
    checks++; if (bus_def.seed !== SEED_01_20) begin errors++; $display("FAIL t1_seed: got %h expected %h", bus_def.seed, SEED_01_20); end
    checks++; if (bus_def.collecting !== 1'b0) begin errors++; $display("FAIL t1_idle: got %b expected 0", bus_def.collecting); end
    checks++; if (bus_def.word_count !== 6'd0) begin errors++; $display("FAIL t1_count0: got %0d expected 0", bus_def.word_count); end
    tick();
    tick();
    checks++; if (bus_def.seed !== SEED_01_20) begin errors++; $display("FAIL t1_seed_stable: got %h expected %h", bus_def.seed, SEED_01_20); end
    checks++; if (bus_def.seed_valid !== 1'b1) begin errors++; $display("FAIL t1_valid_stable: got %b expected 1", bus_def.seed_valid); end
    bus_def.seed_ready = 1'b1;
    tick();
    bus_def.seed_ready = 1'b0;
    checks++; if (bus_def.seed_valid !== 1'b0) begin errors++; $display("FAIL t1_consumed_valid: got %b expected 0", bus_def.seed_valid); end
    checks++; if (bus_def.seed !== 256'h0) begin errors++; $display("FAIL t1_zeroized: got %h expected 0", bus_def.seed); end
  endtask

  task automatic test_rct();
    bus_def.start = 1'b1;
    tick();
    bus_def.start = 1'b0;
    feed_def(8'h11);
    feed_def(8'hAA);
    feed_def(8'hAA);
    feed_def(8'hAA);
    checks++; if (bus_def.health_fail !== 1'b0) begin errors++; $display("FAIL t2_no_trip_at_3: got %b expected 0", bus_def.health_fail); end
    checks++; if (bus_def.word_count !== 6'd4) begin errors++; $display("FAIL t2_count4: got %0d expected 4", bus_def.word_count); end
    feed_def(8'hAA);
    bus_def.trng_valid = 1'b0;
    checks++; if (bus_def.health_fail !== 1'b1) begin errors++; $display("FAIL t2_health_fail: got %b expected 1", bus_def.health_fail); end
    checks++; if (bus_def.trng_ready !== 1'b0) begin errors++; $display("FAIL t2_trng_ready: got %b expected 0", bus_def.trng_ready); end
    checks++; if (bus_def.word_count !== 6'd0) begin errors++; $display("FAIL t2_count0: got %0d expected 0", bus_def.word_count); end
    checks++; if (bus_def.seed_valid !== 1'b0) begin errors++; $display("FAIL t2_seed_valid: got %b expected 0", bus_def.seed_valid); end
    tick();
    checks++; if (bus_def.health_fail !== 1'b1) begin errors++; $display("FAIL t2_sticky: got %b expected 1", bus_def.health_fail); end
    bus_def.start = 1'b1;
    tick();
    bus_def.start = 1'b0;
    checks++; if (bus_def.health_fail !== 1'b0) begin errors++; $display("FAIL t2_restart_clear: got %b expected 0", bus_def.health_fail); end
    checks++; if (bus_def.collecting !== 1'b1) begin errors++; $display("FAIL t2_restart_collect: got %b expected 1", bus_def.collecting); end
    bus_def.abort = 1'b1;
    tick();
    bus_def.abort = 1'b0;
    checks++; if (bus_def.collecting !== 1'b0) begin errors++; $display("FAIL t2_abort_idle: got %b expected 0", bus_def.collecting); end
  endtask

  task automatic test_continuous_backpressure();
    bus_cont.start = 1'b1;
    tick();
    bus_cont.start = 1'b0;
    for (int i = 1; i <= 32; i++) feed_cont(8'(i));
    checks++; if (bus_cont.seed_valid !== 1'b1) begin errors++; $display("FAIL t3_first_valid: got %b expected 1", bus_cont.seed_valid); end
    checks++; if (bus_cont.seed !== SEED_01_20) begin errors++; $display("FAIL t3_first_seed: got %h expected %h", bus_cont.seed, SEED_01_20); end
    checks++; if (bus_cont.collecting !== 1'b1) begin errors++; $display("FAIL t3_refill: got %b expected 1", bus_cont.collecting); end
    checks++; if (bus_cont.word_count !== 6'd0) begin errors++; $display("FAIL t3_count0: got %0d expected 0", bus_cont.word_count); end
    for (int i = 33; i <= 64; i++) begin
      feed_cont(8'(i));
      if (i == 40) begin
        checks++; if (bus_cont.seed !== SEED_01_20) begin errors++; $display("FAIL t3_held_stable: got %h expected %h", bus_cont.seed, SEED_01_20); end
      end
    end
    bus_cont.trng_data = 8'h99;
    checks++; if (bus_cont.trng_ready !== 1'b0) begin errors++; $display("FAIL t3_full_ready: got %b expected 0", bus_cont.trng_ready); end
    checks++; if (bus_cont.collecting !== 1'b0) begin errors++; $display("FAIL t3_full_state: got %b expected 0", bus_cont.collecting); end
    checks++; if (bus_cont.word_count !== 6'd32) begin errors++; $display("FAIL t3_full_count: got %0d expected 32", bus_cont.word_count); end
    checks++; if (bus_cont.seed !== SEED_01_20) begin errors++; $display("FAIL t3_full_seed: got %h expected %h", bus_cont.seed, SEED_01_20); end
    tick();
    tick();
    checks++; if (bus_cont.word_count !== 6'd32) begin errors++; $display("FAIL t3_backpressure: got %0d expected 32", bus_cont.word_count); end
    bus_cont.seed_ready = 1'b1;
    tick();
    bus_cont.seed_ready = 1'b0;
    checks++; if (bus_cont.seed !== SEED_21_40) begin errors++; $display("FAIL t3_second_seed: got %h expected %h", bus_cont.seed, SEED_21_40); end
    checks++; if (bus_cont.seed_valid !== 1'b1) begin errors++; $display("FAIL t3_reload_valid: got %b expected 1", bus_cont.seed_valid); end
    checks++; if (bus_cont.collecting !== 1'b1) begin errors++; $display("FAIL t3_resume: got %b expected 1", bus_cont.collecting); end
    checks++; if (bus_cont.word_count !== 6'd0) begin errors++; $display("FAIL t3_reload_count: got %0d expected 0", bus_cont.word_count); end
    tick();
    bus_cont.trng_valid = 1'b0;
    checks++; if (bus_cont.word_count !== 6'd1) begin errors++; $display("FAIL t3_resume_count: got %0d expected 1", bus_cont.word_count); end
  endtask

  task automatic test_abort();
    bus_def.start = 1'b1;
    tick();
    bus_def.start = 1'b0;
    for (int i = 0; i < 10; i++) feed_def(8'hF0 + 8'(i));
    checks++; if (bus_def.word_count !== 6'd10) begin errors++; $display("FAIL t4_count10: got %0d expected 10", bus_def.word_count); end
    bus_def.trng_data = 8'h77;
    bus_def.abort = 1'b1;
    tick();
    bus_def.abort = 1'b0;
    bus_def.trng_valid = 1'b0;
    checks++; if (bus_def.word_count !== 6'd0) begin errors++; $display("FAIL t4_abort_count: got %0d expected 0", bus_def.word_count); end
    checks++; if (bus_def.collecting !== 1'b0) begin errors++; $display("FAIL t4_abort_idle: got %b expected 0", bus_def.collecting); end
    bus_def.start = 1'b1;
    bus_def.abort = 1'b1;
    tick();
    bus_def.abort = 1'b0;
    checks++; if (bus_def.collecting !== 1'b0) begin errors++; $display("FAIL t4_abort_wins: got %b expected 0", bus_def.collecting); end
    tick();
    bus_def.start = 1'b0;
    for (int i = 0; i < 32; i++) feed_def(8'h40 + 8'(i));
    bus_def.trng_valid = 1'b0;
    checks++; if (bus_def.seed !== SEED_40_5F) begin errors++; $display("FAIL t4_seed: got %h expected %h", bus_def.seed, SEED_40_5F); end
    checks++; if (bus_def.seed_valid !== 1'b1) begin errors++; $display("FAIL t4_valid: got %b expected 1", bus_def.seed_valid); end
    bus_def.seed_ready = 1'b1;
    tick();
    bus_def.seed_ready = 1'b0;
  endtask

  task automatic test_wide_words();
    logic [31:0] words [4];
    words[0] = 32'hDEADBEEF;
    words[1] = 32'h01234567;
    words[2] = 32'h89ABCDEF;
    words[3] = 32'hCAFEF00D;
    bus_w32.start = 1'b1;
    tick();
    bus_w32.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_w32.trng_valid = 1'b1;
      bus_w32.trng_data  = words[i];
      tick();
    end
    bus_w32.trng_valid = 1'b0;
    checks++; if (bus_w32.seed !== SEED_W32) begin errors++; $display("FAIL t5_seed: got %h expected %h", bus_w32.seed, SEED_W32); end
    checks++; if (bus_w32.seed_valid !== 1'b1) begin errors++; $display("FAIL t5_valid: got %b expected 1", bus_w32.seed_valid); end
    checks++; if (bus_w32.word_count !== 3'd0) begin errors++; $display("FAIL t5_count: got %0d expected 0", bus_w32.word_count); end
  endtask

  task automatic test_async_reset();
    bus_def.start = 1'b1;
    tick();
    bus_def.start = 1'b0;
    for (int i = 1; i <= 32; i++) feed_def(8'(i));
    bus_def.trng_valid = 1'b0;
    bus_def.start = 1'b1;
    tick();
    bus_def.start = 1'b0;
    for (int i = 0; i < 10; i++) feed_def(8'h40 + 8'(i));
    bus_def.trng_valid = 1'b0;
    checks++; if (bus_def.seed_valid !== 1'b1) begin errors++; $display("FAIL t6_pre_valid: got %b expected 1", bus_def.seed_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus_def.seed !== 256'h0) begin errors++; $display("FAIL t6_seed: got %h expected 0", bus_def.seed); end
    checks++; if (bus_def.seed_valid !== 1'b0) begin errors++; $display("FAIL t6_valid: got %b expected 0", bus_def.seed_valid); end
    checks++; if (bus_def.collecting !== 1'b0) begin errors++; $display("FAIL t6_collecting: got %b expected 0", bus_def.collecting); end
    checks++; if (bus_def.trng_ready !== 1'b0) begin errors++; $display("FAIL t6_trng_ready: got %b expected 0", bus_def.trng_ready); end
    checks++; if (bus_def.word_count !== 6'd0) begin errors++; $display("FAIL t6_count: got %0d expected 0", bus_def.word_count); end
    checks++; if (bus_w32.seed !== 128'h0) begin errors++; $display("FAIL t6_w32_seed: got %h expected 0", bus_w32.seed); end
    @(negedge clk);
    rst = 1'b0;
    bus_def.start = 1'b1;
    tick();
    bus_def.start = 1'b0;
    for (int i = 1; i <= 32; i++) feed_def(8'(i));
    bus_def.trng_valid = 1'b0;
    checks++; if (bus_def.seed !== SEED_01_20) begin errors++; $display("FAIL t6_after_seed: got %h expected %h", bus_def.seed, SEED_01_20); end
    checks++; if (bus_def.seed_valid !== 1'b1) begin errors++; $display("FAIL t6_after_valid: got %b expected 1", bus_def.seed_valid); end
  endtask

  initial begin
    bus_def.start = 1'b0;  bus_def.abort = 1'b0;  bus_def.trng_valid = 1'b0;
    bus_def.trng_data = '0; bus_def.seed_ready = 1'b0;
    bus_cont.start = 1'b0; bus_cont.abort = 1'b0; bus_cont.trng_valid = 1'b0;
    bus_cont.trng_data = '0; bus_cont.seed_ready = 1'b0;
    bus_w32.start = 1'b0;  bus_w32.abort = 1'b0;  bus_w32.trng_valid = 1'b0;
    bus_w32.trng_data = '0; bus_w32.seed_ready = 1'b0;
    test_reset();
    test_single_seed();
    test_rct();
    test_continuous_backpressure();
    test_abort();
    test_wide_words();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
